// File: rtl/tt_um_load_db.sv
// Double-buffered ternary weight loader: beats stream into a shadow image
// while the active image keeps driving the MAC array until a commit.
module tt_um_load_db #(
    parameter  int MAX_IN_LEN   = 16,
    parameter  int MAX_OUT_LEN  = 8,
    parameter  int WIDTH        = 2,
    localparam int MAX_IN_BITS  = $clog2(MAX_IN_LEN),
    localparam int MAX_OUT_BITS = $clog2(MAX_OUT_LEN),
    localparam int WIDTH_BITS   = $clog2(WIDTH)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   ena,
    input  logic                                   i_start,
    input  logic [MAX_OUT_BITS-1:0]                i_rows,
    input  logic                                   i_valid,
    input  logic [MAX_IN_LEN-1:0]                  i_data,
    output logic                                   o_ready,
    input  logic                                   i_swap,
    output logic [WIDTH*MAX_IN_LEN*MAX_OUT_LEN-1:0] o_weights,
    output logic                                   o_done,
    output logic                                   o_pending,
    output logic                                   o_busy
);

    localparam int ROW_SPAN = MAX_OUT_LEN * WIDTH;
    localparam int CNT_BITS = MAX_OUT_BITS + WIDTH_BITS;
    localparam int TOTAL    = ROW_SPAN * MAX_IN_LEN;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FULL
    } state_t;

    state_t                    r_state;
    logic [CNT_BITS-1:0]       r_count;
    logic [MAX_OUT_BITS-1:0]   r_rows;
    logic [TOTAL-1:0]          r_shadow;
    logic [TOTAL-1:0]          r_active;
    logic                      r_done;
    logic                      r_pending;
    logic                      r_busy;

    logic [CNT_BITS-1:0]       w_last;
    logic [ROW_SPAN-1:0]       w_row_onehot;
    logic [TOTAL-1:0]          w_mask;
    logic [TOTAL-1:0]          w_data;

    assign w_last       = {r_rows, {WIDTH_BITS{1'b1}}};
    assign w_row_onehot = ROW_SPAN'(1) << r_count;

    // Each column owns a contiguous ROW_SPAN slice starting at flat index {c, 0}.
    generate
        for (genvar gi = 0; gi < MAX_IN_LEN; gi++) begin : g_col
            localparam logic [MAX_IN_BITS-1:0] COL = MAX_IN_BITS'(gi);
            localparam logic [CNT_BITS-1:0]    ZERO_CNT = '0;
            assign w_mask[{COL, ZERO_CNT} +: ROW_SPAN] = w_row_onehot;
            assign w_data[{COL, ZERO_CNT} +: ROW_SPAN] = {ROW_SPAN{i_data[gi]}};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_rows    <= '0;
            r_shadow  <= '0;
            r_active  <= '0;
            r_done    <= 1'b0;
            r_pending <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            // o_done stays a single-cycle pulse even if ena drops right after it.
            r_done <= 1'b0;
            if (ena) begin
                if (r_state == S_FULL && i_swap) begin
                    r_active <= r_shadow;
                end
                if (i_start) begin
                    r_state   <= S_LOAD;
                    r_count   <= '0;
                    r_rows    <= i_rows;
                    r_shadow  <= '0;
                    r_busy    <= 1'b1;
                    r_pending <= 1'b0;
                end else begin
                    case (r_state)
                        S_LOAD: begin
                            if (i_valid) begin
                                r_shadow <= (r_shadow & ~w_mask) | (w_data & w_mask);
                                if (r_count == w_last) begin
                                    r_state   <= S_FULL;
                                    r_done    <= 1'b1;
                                    r_pending <= 1'b1;
                                    r_busy    <= 1'b0;
                                end else begin
                                    r_count <= r_count + CNT_BITS'(1);
                                end
                            end
                        end
                        S_FULL: begin
                            if (i_swap) begin
                                r_state   <= S_IDLE;
                                r_pending <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign o_ready   = (r_state == S_LOAD) & ena;
    assign o_weights = r_active;
    assign o_done    = r_done;
    assign o_pending = r_pending;
    assign o_busy    = r_busy;

endmodule

// File: tb/tb_tt_um_load_db.sv
// Bench for tt_um_load_db: directed vector table, scenario sequences and a
// randomized run, all compared against a behavioural loader model.
module tb_tt_um_load_db;

    localparam int NI = 16;
    localparam int NO = 8;
    localparam int W  = 2;
    localparam int NB = NI * NO * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic          i_start;
    logic [2:0]    i_rows;
    logic          i_valid;
    logic [15:0]   i_data;
    logic          o_ready;
    logic          i_swap;
    logic [NB-1:0] o_weights;
    logic          o_done;
    logic          o_pending;
    logic          o_busy;

    tt_um_load_db dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .i_start   (i_start),
        .i_rows    (i_rows),
        .i_valid   (i_valid),
        .i_data    (i_data),
        .o_ready   (o_ready),
        .i_swap    (i_swap),
        .o_weights (o_weights),
        .o_done    (o_done),
        .o_pending (o_pending),
        .o_busy    (o_busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: mode 0 = no load, 1 = streaming, 2 = complete and uncommitted.
    int            m_mode;
    int            m_beats;
    int            m_rows;
    logic [NB-1:0] m_shadow;
    logic [NB-1:0] m_active;
    logic          m_done;

    typedef struct {
        logic        ena;
        logic        start;
        logic [2:0]  rows;
        logic        valid;
        logic [15:0] data;
        logic        swap;
        logic        ready_e;
        logic        done_e;
        logic        pend_e;
        logic        busy_e;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_mode = 0; m_beats = 0; m_rows = 0;
            m_shadow = '0; m_active = '0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (ena) begin
                if (m_mode == 2 && i_swap) m_active = m_shadow;
                if (i_start) begin
                    m_mode = 1; m_beats = 0; m_rows = int'(i_rows); m_shadow = '0;
                end else if (m_mode == 1 && i_valid) begin
                    for (int c = 0; c < NI; c++) m_shadow[c*NO*W + m_beats] = i_data[c];
                    m_beats++;
                    if (m_beats == (m_rows + 1) * W) begin
                        m_mode = 2;
                        m_done = 1'b1;
                    end
                end else if (m_mode == 2 && i_swap) begin
                    m_mode = 0;
                end
            end
        end
    endtask

    task automatic cycle();
        #1;
        chk("ready", o_ready, (m_mode == 1) && ena);
        model_step();
        @(posedge clk);
        #1;
        chk("weights", o_weights, m_active);
        chk("done", o_done, m_done);
        chk("pending", o_pending, m_mode == 2);
        chk("busy", o_busy, m_mode == 1);
    endtask

    task automatic drive(input logic st, input logic [2:0] rw, input logic v,
                         input logic [15:0] d, input logic sw);
        i_start = st; i_rows = rw; i_valid = v; i_data = d; i_swap = sw;
    endtask

    task automatic start_load(input logic [2:0] rw);
        drive(1'b1, rw, 1'b0, 16'h0, 1'b0);
        cycle();
    endtask

    task automatic beat(input logic [15:0] d);
        drive(1'b0, 3'd0, 1'b1, d, 1'b0);
        cycle();
    endtask

    task automatic do_swap();
        drive(1'b0, 3'd0, 1'b0, 16'h0, 1'b1);
        cycle();
    endtask

    initial begin
        logic [NB-1:0] exp;
        logic [NB-1:0] prev;
        logic [15:0]   d[8];

        rst = 1'b1; ena = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 16'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        m_mode = 0; m_beats = 0; m_rows = 0; m_shadow = '0; m_active = '0; m_done = 1'b0;
        cycle();
        chk("reset_weights", o_weights, '0);
        chk("reset_ready", o_ready, 1'b0);
        rst = 1'b0;

        // ena start rows valid data swap | ready done pend busy
        tbl[0] = '{1'b1, 1'b1, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 3'd0, 1'b1, 16'hA5A5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 3'd0, 1'b1, 16'h0F0F, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 3'd0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 3'd1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 3'd1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < 9; i++) begin
            ena = tbl[i].ena;
            drive(tbl[i].start, tbl[i].rows, tbl[i].valid, tbl[i].data, tbl[i].swap);
            #1;
            chk("tbl_ready", o_ready, tbl[i].ready_e);
            cycle();
            chk("tbl_done", o_done, tbl[i].done_e);
            chk("tbl_pending", o_pending, tbl[i].pend_e);
            chk("tbl_busy", o_busy, tbl[i].busy_e);
            $display("vec %0d: start=%b valid=%b data=%h swap=%b -> done=%b pend=%b busy=%b",
                     i, tbl[i].start, tbl[i].valid, tbl[i].data, tbl[i].swap, o_done, o_pending, o_busy);
        end
        exp = '0;
        for (int c = 0; c < NI; c++) begin
            exp[c*16 + 0] = c[0] ? 1'b1 : 1'b0;
            exp[c*16 + 1] = ((c % 8) < 4) ? 1'b1 : 1'b0;
        end
        exp = '0;
        for (int c = 0; c < NI; c++) begin
            d[0] = 16'hA5A5; d[1] = 16'h0F0F;
            exp[c*16 + 0] = d[0][c];
            exp[c*16 + 1] = d[1][c];
        end
        chk("tbl_weights", o_weights, exp);
        ena = 1'b1;

        // Diagonal load with all eight rows.
        rst = 1'b1; drive(1'b0, 3'd0, 1'b0, 16'h0, 1'b0); cycle(); rst = 1'b0;
        start_load(3'd7);
        for (int k = 0; k < 16; k++) begin
            beat(16'h0001 << k);
            chk("seq1_done", o_done, k == 15);
        end
        drive(1'b0, 3'd0, 1'b0, 16'h0, 1'b0); cycle();
        chk("seq1_done_once", o_done, 1'b0);
        do_swap();
        exp = '0;
        for (int k = 0; k < 16; k++) exp[k*16 + k] = 1'b1;
        chk("seq1_weights", o_weights, exp);
        $display("seq1 diagonal load: weights=%h", o_weights);

        // Three rows of ones; the active image must not move before commit.
        prev = exp;
        start_load(3'd2);
        for (int k = 0; k < 6; k++) beat(16'hFFFF);
        chk("seq2_hold", o_weights, prev);
        do_swap();
        exp = '0;
        for (int c = 0; c < NI; c++)
            for (int r = 0; r < 6; r++) exp[c*16 + r] = 1'b1;
        chk("seq2_weights", o_weights, exp);
        $display("seq2 three-row load: weights=%h", o_weights);

        // Restart after five beats; the dropped beat rides on the restart cycle.
        start_load(3'd7);
        for (int k = 0; k < 5; k++) beat(16'($urandom));
        drive(1'b1, 3'd7, 1'b1, 16'($urandom), 1'b0); cycle();
        for (int k = 0; k < 16; k++) begin
            beat(16'hFFFF);
            chk("seq3_done", o_done, k == 15);
        end
        do_swap();
        chk("seq3_weights", o_weights, {NB{1'b1}});
        $display("seq3 restart mid-load: weights=%h", o_weights);

        // ena low for three cycles with valid held.
        start_load(3'd3);
        for (int k = 0; k < 8; k++) d[k] = 16'($urandom);
        for (int k = 0; k < 3; k++) beat(d[k]);
        ena = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 3'd0, 1'b1, 16'($urandom), 1'b0);
            cycle();
            chk("seq4_ready", o_ready, 1'b0);
        end
        ena = 1'b1;
        for (int k = 3; k < 8; k++) beat(d[k]);
        do_swap();
        exp = '0;
        for (int c = 0; c < NI; c++)
            for (int k = 0; k < 8; k++) exp[c*16 + k] = d[k][c];
        chk("seq4_weights", o_weights, exp);
        $display("seq4 ena stall: weights=%h", o_weights);

        // Start and swap together while FULL.
        start_load(3'd0);
        d[0] = 16'($urandom); d[1] = 16'($urandom);
        beat(d[0]); beat(d[1]);
        drive(1'b1, 3'd0, 1'b0, 16'h0, 1'b1); cycle();
        exp = '0;
        for (int c = 0; c < NI; c++) begin
            exp[c*16 + 0] = d[0][c];
            exp[c*16 + 1] = d[1][c];
        end
        chk("seq5_weights", o_weights, exp);
        chk("seq5_busy", o_busy, 1'b1);
        chk("seq5_pending", o_pending, 1'b0);
        $display("seq5 start+swap: weights=%h busy=%b", o_weights, o_busy);

        // Reset while FULL, then a swap that must do nothing.
        beat(16'($urandom)); beat(16'($urandom));
        rst = 1'b1; drive(1'b0, 3'd0, 1'b0, 16'h0, 1'b0); cycle(); rst = 1'b0;
        chk("seq6_weights", o_weights, '0);
        chk("seq6_done", o_done, 1'b0);
        chk("seq6_pending", o_pending, 1'b0);
        chk("seq6_busy", o_busy, 1'b0);
        chk("seq6_ready", o_ready, 1'b0);
        do_swap();
        chk("seq6_swap", o_weights, '0);
        $display("seq6 reset in FULL: weights=%h", o_weights);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom % 100) == 0;
            ena = ($urandom % 10) != 0;
            drive(($urandom % 20) == 0, 3'($urandom), ($urandom % 10) < 7,
                  16'($urandom), ($urandom % 5) == 0);
            cycle();
        end
        rst = 1'b0;
        $display("random run: 3000 cycles");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
